image_stream_src: RTL and testbench

Frame-stream source that replays a stored 8-bit grayscale image into the image-processing pipeline. It reads pixels from a synchronous-read memory and drives the pre_frame_vsync / pre_frame_hsync / pre_frame_clken / pre_img_y stream that the line buffers and window filters consume. It is the transmit end of that stream interface and provides programmable blanking and pixel pacing for simulation and on-chip test.

---
 rtl/image_stream_src.sv | 123 ++++++++++++
 tb/tb_image_stream_src.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/image_stream_src.sv
// image_stream_src: replays a stored 8-bit image from sync-read memory as a vsync/hsync/clken/y pixel stream (clk, rst, start in; mem_rd_* to memory; pre_frame_*/pre_img_y, busy, frame_done out)
module image_stream_src #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int H_BLANK = 4,
  parameter int V_LEAD  = 8,
  parameter int V_TAIL  = 8,
  parameter int PIX_GAP = 0,
  parameter int ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              pre_frame_vsync,
  output logic              pre_frame_hsync,
  output logic              pre_frame_clken,
  output logic [7:0]        pre_img_y,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = 16;
  localparam logic [CW-1:0] W_M  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_M  = CW'(IMG_H - 1);
  localparam logic [CW-1:0] HB_M = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VL_M = CW'(V_LEAD - 1);
  localparam logic [CW-1:0] VT_M = CW'(V_TAIL - 1);
  localparam logic [CW-1:0] GAP  = CW'(PIX_GAP);
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_ACT, S_BLANK, S_TAIL, S_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, h_cnt, h_n, v_cnt, v_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic vs, hs;
  logic [1:0] vs_d, hs_d, ce_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      addr      <= '0;
      vs_d      <= '0;
      hs_d      <= '0;
      ce_d      <= '0;
      pre_img_y <= '0;
      frame_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      h_cnt     <= h_n;
      v_cnt     <= v_n;
      addr      <= addr_n;
      vs_d      <= {vs_d[0], vs};
      hs_d      <= {hs_d[0], hs};
      ce_d      <= {ce_d[0], mem_rd_en};
      pre_img_y <= ce_d[0] ? mem_rd_data : 8'd0;
      frame_done <= vs_d[1] & ~vs_d[0];
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    h_n       = h_cnt;
    v_n       = v_cnt;
    addr_n    = addr;
    vs        = 1'b0;
    hs        = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = start ? S_LEAD : S_IDLE;
        if (start) begin
          cnt_n  = '0;
          h_n    = '0;
          v_n    = '0;
          addr_n = '0;
        end
      end
      S_LEAD: begin
        vs      = 1'b1;
        cnt_n   = cnt == VL_M ? '0 : cnt + 1'b1;
        state_n = cnt == VL_M ? S_ACT : S_LEAD;
      end
      S_ACT: begin
        vs        = 1'b1;
        hs        = 1'b1;
        mem_rd_en = cnt == '0;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (h_cnt == W_M) begin
          state_n = S_BLANK;
          h_n     = '0;
          addr_n  = v_cnt == H_M ? addr : addr + 1'b1;
        end else begin
          h_n    = h_cnt + 1'b1;
          cnt_n  = GAP;
          addr_n = addr + 1'b1;
        end
      end
      S_BLANK: begin
        vs    = 1'b1;
        cnt_n = cnt == HB_M ? '0 : cnt + 1'b1;
        if (cnt == HB_M) begin
          v_n     = v_cnt + 1'b1;
          state_n = v_cnt == H_M ? S_TAIL : S_ACT;
        end
      end
      S_TAIL: begin
        vs      = 1'b1;
        cnt_n   = cnt == VT_M ? '0 : cnt + 1'b1;
        state_n = cnt == VT_M ? S_DONE : S_TAIL;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign mem_rd_addr     = addr;
  assign pre_frame_vsync = vs_d[1];
  assign pre_frame_hsync = hs_d[1];
  assign pre_frame_clken = ce_d[1];
  assign busy            = (state != S_IDLE) | (|vs_d) | frame_done;
endmodule

// File: tb/tb_image_stream_src.sv
// tb_image_stream_src: random start/rst stimulus on three image_stream_src configurations checked against a per-cycle frame-timing model
module tb_image_stream_src;
  typedef struct packed {int w; int h; int hb; int vl; int vt; int g;} cfg_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] vs, hs, ce, bz, fd, en;
  logic [7:0] y [3];
  logic [7:0] md [3];
  logic [18:0] ad [3];
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int cur_s [3];
  int prv_s [3];
  bit cur_v [3];
  bit prv_v [3];
  int fd_at [3];
  int vs_at [3];
  bit last_rst = 1'b1;
  bit prev_hs = 1'b0;
  bit prev_vs = 1'b0;
  int pix = 0;
  int lines = 0;
  int k;
  always #5 clk = ~clk;
  image_stream_src #(.IMG_W(4), .IMG_H(3), .H_BLANK(2), .V_LEAD(3), .V_TAIL(2), .PIX_GAP(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(en[0]), .mem_rd_addr(ad[0]), .mem_rd_data(md[0]),
    .pre_frame_vsync(vs[0]), .pre_frame_hsync(hs[0]), .pre_frame_clken(ce[0]), .pre_img_y(y[0]),
    .busy(bz[0]), .frame_done(fd[0]));
  image_stream_src #(.IMG_W(4), .IMG_H(3), .H_BLANK(2), .V_LEAD(3), .V_TAIL(2), .PIX_GAP(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(en[1]), .mem_rd_addr(ad[1]), .mem_rd_data(md[1]),
    .pre_frame_vsync(vs[1]), .pre_frame_hsync(hs[1]), .pre_frame_clken(ce[1]), .pre_img_y(y[1]),
    .busy(bz[1]), .frame_done(fd[1]));
  image_stream_src #(.IMG_W(2), .IMG_H(1), .H_BLANK(1), .V_LEAD(1), .V_TAIL(1), .PIX_GAP(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(en[2]), .mem_rd_addr(ad[2]), .mem_rd_data(md[2]),
    .pre_frame_vsync(vs[2]), .pre_frame_hsync(hs[2]), .pre_frame_clken(ce[2]), .pre_img_y(y[2]),
    .busy(bz[2]), .frame_done(fd[2]));
  always @(posedge clk) for (int i = 0; i < 3; i++) md[i] <= ad[i][7:0];
  function automatic cfg_t cfg(input int i);
    return i == 0 ? '{4, 3, 2, 3, 2, 0} : i == 1 ? '{4, 3, 2, 3, 2, 2} : '{2, 1, 1, 1, 1, 0};
  endfunction
  function automatic int flen(input cfg_t c);
    return c.vl + c.h * (c.w + (c.w - 1) * c.g + c.hb) + c.vt;
  endfunction
  function automatic logic [12:0] contrib(input cfg_t c, input int o);
    int la, l, f, r;
    logic hv, cv;
    logic [7:0] pv;
    la = c.w + (c.w - 1) * c.g;
    l  = la + c.hb;
    f  = flen(c);
    r  = o - c.vl;
    hv = 1'b0;
    cv = 1'b0;
    pv = 8'd0;
    if (r >= 0 && r < c.h * l) begin
      hv = (r % l) < la;
      cv = hv && ((r % l) % (c.g + 1)) == 0;
      if (cv) pv = 8'((r / l) * c.w + (r % l) / (c.g + 1));
    end
    return {(o >= 0 && o < f), hv, cv, (o >= -2 && o <= f), (o == f), pv};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input logic st, input logic rs);
    logic [12:0] e;
    cfg_t c;
    for (int i = 0; i < 3; i++) begin
      c = cfg(i);
      e = '0;
      if (cur_v[i]) e |= contrib(c, cyc - cur_s[i] - 2);
      if (prv_v[i]) e |= contrib(c, cyc - prv_s[i] - 2);
      check($sformatf("inst%0d_out", i), {19'd0, vs[i], hs[i], ce[i], bz[i], fd[i], y[i]}, {19'd0, e});
      check($sformatf("inst%0d_addr_max", i), {31'd0, int'(ad[i]) <= c.w * c.h - 1}, 32'd1);
      if (fd[i] && fd_at[i] < 0) fd_at[i] = cyc;
      if (vs[i] && vs_at[i] < 0) vs_at[i] = cyc;
    end
    if (last_rst) begin
      pix = 0;
      lines = 0;
    end else begin
      if (ce[1]) begin
        check("clken_in_sync", {30'd0, hs[1], vs[1]}, 32'd3);
        pix++;
      end
      if (prev_hs && !hs[1]) begin
        check("pix_per_line", pix, 4);
        pix = 0;
        lines++;
      end
      if (prev_vs && !vs[1]) begin
        check("lines_per_frame", lines, 3);
        lines = 0;
      end
    end
    prev_hs = hs[1];
    prev_vs = vs[1];
    start = st;
    rst = rs;
    last_rst = rs;
    for (int i = 0; i < 3; i++) begin
      if (rs) begin
        cur_v[i] = 1'b0;
        prv_v[i] = 1'b0;
      end else if (st && (!cur_v[i] || cyc - cur_s[i] >= flen(cfg(i)))) begin
        prv_v[i] = cur_v[i];
        prv_s[i] = cur_s[i];
        cur_v[i] = 1'b1;
        cur_s[i] = cyc + 1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    @(negedge clk);
    cyc = 1;
    repeat (2) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      fd_at[i] = -1;
      vs_at[i] = -1;
    end
    k = cyc;
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inst%0d_vsync_rise", i), vs_at[i] - k, 3);
      check($sformatf("inst%0d_done_latency", i), fd_at[i] - k, i == 0 ? 26 : i == 1 ? 44 : 8);
    end
    repeat (100) step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (50) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);
    repeat (3000) step($urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0);
    repeat (60) step(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
